// File: rtl/text_raster_pkg.sv
// text_raster shared constants: default geometry, derived cell grid,
// default colours and the built-in font pattern.
package text_raster_pkg;

  localparam int DEF_GLYPH_W  = 8;
  localparam int DEF_GLYPH_H  = 16;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam int DEF_COLS = DEF_H_ACTIVE / DEF_GLYPH_W;
  localparam int DEF_ROWS = DEF_V_ACTIVE / DEF_GLYPH_H;

  localparam logic [7:0] DEF_FG = 8'hFF;
  localparam logic [7:0] DEF_BG = 8'h4B;

  function automatic logic [31:0] glyph_fill(
    input int code,
    input int gy
  );
    if (code == 0) return '0;
    if (code == 255) return '1;
    return 32'((code * 29) ^ (gy * 83) ^ 'h5A);
  endfunction

endpackage

// File: rtl/text_raster_font_rom.sv
// text_raster glyph ROM: 256 glyphs of GLYPH_H rows,
// one registered read per cycle, contents untouched by reset.
module font_rom
  import text_raster_pkg::*;
#(
  parameter int    GLYPH_W   = DEF_GLYPH_W,
  parameter int    GLYPH_H   = DEF_GLYPH_H,
  parameter string FONT_FILE = "font.mem"
) (
  input  logic                         clk,
  input  logic [7+$clog2(GLYPH_H):0]  addr_i,
  output logic [GLYPH_W-1:0]          row_o
);

  logic [GLYPH_W-1:0] rom [256*GLYPH_H];

  initial begin
    for (int i = 0; i < 256*GLYPH_H; i++)
      rom[i] = GLYPH_W'(glyph_fill(
        i / GLYPH_H, i % GLYPH_H));
  end

  always_ff @(posedge clk)
    row_o <= rom[addr_i];

endmodule

// File: rtl/text_raster.sv
// text_raster: 3-stage character-cell rasteriser with external
// screen memory, glyph ROM, global invert and blinking cursor.
module text_raster
  import text_raster_pkg::*;
#(
  parameter int    GLYPH_W    = DEF_GLYPH_W,
  parameter int    GLYPH_H    = DEF_GLYPH_H,
  parameter int    H_ACTIVE   = DEF_H_ACTIVE,
  parameter int    V_ACTIVE   = DEF_V_ACTIVE,
  parameter int    RGB_W      = 8,
  parameter int    BLINK_LOG2 = 5,
  parameter string FONT_FILE  = "font.mem"
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [10:0]      x,
  input  logic [10:0]      y,
  input  logic             pix_valid,
  output logic [15:0]      char_addr,
  input  logic [7:0]       char_code,
  input  logic [RGB_W-1:0] fg_color,
  input  logic [RGB_W-1:0] bg_color,
  input  logic             invert,
  input  logic             cursor_en,
  input  logic [6:0]       cursor_col,
  input  logic [5:0]       cursor_row,
  output logic [RGB_W-1:0] rgb,
  output logic             rgb_valid
);

  localparam int GX_W = $clog2(GLYPH_W);
  localparam int GY_W = $clog2(GLYPH_H);
  localparam int COLS = H_ACTIVE / GLYPH_W;

  typedef struct packed {
    logic [RGB_W-1:0] fg;
    logic [RGB_W-1:0] bg;
    logic             inv;
    logic             cur;
    logic             act;
    logic             vld;
    logic [GX_W-1:0]  gx;
  } pix_t;

  logic [10:0]           col;
  logic [10:0]           row;
  logic [GY_W-1:0]       gy;
  logic                  in_rng;
  logic                  hit;
  pix_t                  s1_d, s1_q;
  pix_t                  s2_q, s3_q;
  logic [GY_W-1:0]       gy1_q, gy2_q;
  logic [7:0]            code_q;
  logic [15:0]           addr_d, addr_q;
  logic [BLINK_LOG2-1:0] frame_d, frame_q;
  logic                  blink_d, blink_q;
  logic [GLYPH_W-1:0]    glyph;
  logic                  pbit;
  logic                  sel;
  logic [RGB_W-1:0]      rgb_d, rgb_q;
  logic                  vld_q;

  always_comb begin
    col    = x >> GX_W;
    row    = y >> GY_W;
    gy     = y[GY_W-1:0];
    in_rng = (x < 11'(H_ACTIVE))
          && (y < 11'(V_ACTIVE));
    hit    = cursor_en
          && (col == 11'(cursor_col))
          && (row == 11'(cursor_row))
          && (gy >= GY_W'(GLYPH_H-2));
    s1_d = '{
      fg:  fg_color,
      bg:  bg_color,
      inv: invert,
      cur: hit && blink_q,
      act: pix_valid && in_rng,
      vld: pix_valid,
      gx:  x[GX_W-1:0]
    };
    addr_d = addr_q;
    if (in_rng)
      addr_d = 16'(row) * 16'(COLS) + 16'(col);
  end

  always_comb begin
    frame_d = frame_q;
    blink_d = blink_q;
    if (pix_valid && x == '0 && y == '0) begin
      frame_d = frame_q + 1'b1;
      if (&frame_q) blink_d = ~blink_q;
    end
  end

  // ~gx == GLYPH_W-1-gx, so column 0 picks the MSB
  always_comb begin
    pbit  = glyph[~s3_q.gx];
    sel   = pbit ^ s3_q.inv ^ s3_q.cur;
    rgb_d = '0;
    if (s3_q.act)
      rgb_d = sel ? s3_q.fg : s3_q.bg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      gy1_q   <= '0;
      gy2_q   <= '0;
      code_q  <= '0;
      addr_q  <= '0;
      frame_q <= '0;
      blink_q <= 1'b0;
      rgb_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      gy1_q   <= gy;
      addr_q  <= addr_d;
      s2_q    <= s1_q;
      gy2_q   <= gy1_q;
      code_q  <= char_code;
      s3_q    <= s2_q;
      frame_q <= frame_d;
      blink_q <= blink_d;
      rgb_q   <= rgb_d;
      vld_q   <= s3_q.vld;
    end
  end

  font_rom #(
    .GLYPH_W   (GLYPH_W),
    .GLYPH_H   (GLYPH_H),
    .FONT_FILE (FONT_FILE)
  ) u_rom (
    .clk    (clk),
    .addr_i ({code_q, gy2_q}),
    .row_o  (glyph)
  );

  assign char_addr = addr_q;
  assign rgb       = rgb_q;
  assign rgb_valid = vld_q;

endmodule

// File: tb/tb_text_raster.sv
// text_raster bench: vector table, line sweep, random pixels
// against a cell/glyph model, mid-line reset and cursor blink.
module tb_text_raster;
  import text_raster_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] x, y;
  logic        pix_valid;
  logic [15:0] char_addr;
  logic [7:0]  char_code;
  logic [7:0]  fg_color, bg_color;
  logic        invert, cursor_en;
  logic [6:0]  cursor_col;
  logic [5:0]  cursor_row;
  logic [7:0]  rgb;
  logic        rgb_valid;

  always #5 clk = ~clk;

  text_raster #(.FONT_FILE("")) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .x          (x),
    .y          (y),
    .pix_valid  (pix_valid),
    .char_addr  (char_addr),
    .char_code  (char_code),
    .fg_color   (fg_color),
    .bg_color   (bg_color),
    .invert     (invert),
    .cursor_en  (cursor_en),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .rgb        (rgb),
    .rgb_valid  (rgb_valid)
  );

  typedef struct {
    int       x;
    int       y;
    bit       pv;
    bit [7:0] fg;
    bit [7:0] bg;
    bit       inv;
    bit       cen;
    int       ccol;
    int       crow;
  } pix_t;

  typedef struct {
    pix_t     p;
    int       code;
    bit [7:0] rgb;
    bit       vld;
    int       addr;
  } vec_t;

  bit [7:0] scr [DEF_COLS*DEF_ROWS];
  bit [7:0] e_rgb [4];
  bit       e_vld [4];
  int       e_addr;
  int       frames;
  int       total;
  int       bad;
  int       vcount;

  assign char_code = (int'(char_addr) < DEF_COLS*DEF_ROWS)
                   ? scr[int'(char_addr)] : 8'h00;

  function automatic bit [7:0] glyph(int code, int gy);
    if (code == 0) return 8'h00;
    if (code == 255) return 8'hFF;
    return 8'((code * 29) ^ (gy * 83) ^ 32'h5A);
  endfunction

  function automatic pix_t idle();
    pix_t p;
    p = '{default: 0};
    p.x = 2047;
    p.y = 2047;
    return p;
  endfunction

  function automatic bit [8:0] mdl(pix_t p);
    int col, row, gx, gy, code;
    bit [7:0] g;
    bit b, cur;
    if (!(p.pv && p.x < 640 && p.y < 480))
      return {p.pv, 8'h00};
    col  = p.x / 8;
    row  = p.y / 16;
    gx   = p.x % 8;
    gy   = p.y % 16;
    code = scr[row*DEF_COLS + col];
    g    = glyph(code, gy);
    b    = g[7-gx];
    cur  = p.cen && col == p.ccol && row == p.crow
        && gy >= 14 && ((frames / 32) % 2 == 1);
    return {1'b1, (b ^ p.inv ^ cur) ? p.fg : p.bg};
  endfunction

  function automatic vec_t mk(
    int x, int y, bit pv, int code,
    bit [7:0] fg, bit [7:0] bg, bit inv, bit cen,
    bit [7:0] r, bit v, int a);
    vec_t t;
    t.p      = idle();
    t.p.x    = x;
    t.p.y    = y;
    t.p.pv   = pv;
    t.p.fg   = fg;
    t.p.bg   = bg;
    t.p.inv  = inv;
    t.p.cen  = cen;
    t.p.ccol = 5;
    t.p.crow = 3;
    t.code   = code;
    t.rgb    = r;
    t.vld    = v;
    t.addr   = a;
    return t;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drive(pix_t p);
    x          = 11'(p.x);
    y          = 11'(p.y);
    pix_valid  = p.pv;
    fg_color   = p.fg;
    bg_color   = p.bg;
    invert     = p.inv;
    cursor_en  = p.cen;
    cursor_col = 7'(p.ccol);
    cursor_row = 6'(p.crow);
  endtask

  task automatic step(pix_t p, bit [7:0] er, bit ev, int ea);
    @(negedge clk);
    chk("rgb", int'(rgb), int'(e_rgb[3]));
    chk("rgb_valid", int'(rgb_valid), int'(e_vld[3]));
    chk("char_addr", int'(char_addr), e_addr);
    if (rgb_valid) vcount++;
    for (int i = 3; i > 0; i--) begin
      e_rgb[i] = e_rgb[i-1];
      e_vld[i] = e_vld[i-1];
    end
    e_rgb[0] = er;
    e_vld[0] = ev;
    e_addr   = ea;
    drive(p);
  endtask

  task automatic step_m(pix_t p);
    bit [8:0] m;
    int ea;
    m  = mdl(p);
    ea = e_addr;
    if (p.x < 640 && p.y < 480)
      ea = (p.y / 16) * DEF_COLS + p.x / 8;
    if (p.pv && p.x == 0 && p.y == 0) frames++;
    step(p, m[7:0], m[8], ea);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(idle());
    reset_n = 1'b0;
    #1;
    chk("rst_rgb_now", int'(rgb), 0);
    chk("rst_vld_now", int'(rgb_valid), 0);
    chk("rst_addr_now", int'(char_addr), 0);
    repeat (2) @(negedge clk);
    chk("rst_rgb_hold", int'(rgb), 0);
    chk("rst_vld_hold", int'(rgb_valid), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e_rgb[i] = '0;
      e_vld[i] = 1'b0;
    end
    e_addr = 0;
    frames = 0;
  endtask

  initial begin
    vec_t tv [12];
    pix_t p;
    int   k, ccol, crow;
    total   = 0;
    bad     = 0;
    vcount  = 0;
    frames  = 0;
    e_addr  = 0;
    reset_n = 1'b1;
    drive(idle());
    for (int i = 0; i < DEF_COLS*DEF_ROWS; i++)
      scr[i] = 8'($urandom);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rgb", int'(rgb), 0);
    chk("reset_vld", int'(rgb_valid), 0);
    chk("reset_addr", int'(char_addr), 0);
    reset_n = 1'b1;

    tv[0]  = mk(9, 17, 1, 'h41, DEF_FG, DEF_BG,
                0, 0, 8'hFF, 1, 81);
    tv[1]  = mk(17, 17, 1, 'hFF, DEF_FG, DEF_BG,
                0, 0, 8'hFF, 1, 82);
    tv[2]  = mk(25, 17, 1, 'h00, DEF_FG, DEF_BG,
                0, 0, 8'h4B, 1, 83);
    tv[3]  = mk(33, 17, 1, 'h00, DEF_FG, DEF_BG,
                1, 0, 8'hFF, 1, 84);
    tv[4]  = mk(41, 17, 1, 'hFF, DEF_FG, DEF_BG,
                1, 0, 8'h4B, 1, 85);
    tv[5]  = mk(700, 10, 1, 0, DEF_FG, DEF_BG,
                0, 0, 8'h00, 1, 85);
    tv[6]  = mk(10, 500, 1, 0, DEF_FG, DEF_BG,
                0, 0, 8'h00, 1, 85);
    tv[7]  = mk(100, 100, 0, 'hFF, DEF_FG, DEF_BG,
                0, 0, 8'h00, 0, 492);
    tv[8]  = mk(639, 479, 1, 'hFF, DEF_FG, DEF_BG,
                0, 0, 8'hFF, 1, 2399);
    tv[9]  = mk(42, 63, 1, 'h00, DEF_FG, DEF_BG,
                0, 1, 8'h4B, 1, 245);
    tv[10] = mk(42, 61, 1, 'h00, 8'h12, 8'h34,
                0, 1, 8'h34, 1, 245);
    tv[11] = mk(50, 40, 1, 'hFF, 8'hA5, 8'h5A,
                0, 0, 8'hA5, 1, 166);

    foreach (tv[i]) begin
      if (tv[i].p.x < 640 && tv[i].p.y < 480)
        scr[(tv[i].p.y / 16) * DEF_COLS + tv[i].p.x / 8]
          = 8'(tv[i].code);
      step(tv[i].p, tv[i].rgb, tv[i].vld, tv[i].addr);
      repeat (3) step(idle(), 8'h00, 1'b0, tv[i].addr);
    end
    step_m(idle());

    for (int i = DEF_COLS; i < 2*DEF_COLS; i++)
      scr[i] = 8'hFF;
    vcount = 0;
    for (int i = 0; i < 640; i++) begin
      p    = idle();
      p.x  = i;
      p.y  = 20;
      p.pv = 1'b1;
      p.fg = DEF_FG;
      p.bg = DEF_BG;
      step_m(p);
    end
    repeat (4) step_m(idle());
    chk("line_valid_cnt", vcount, 640);

    ccol = $urandom_range(0, 79);
    crow = $urandom_range(0, 29);
    repeat (2500) begin
      k      = $urandom_range(0, 9);
      p      = idle();
      p.ccol = ccol;
      p.crow = crow;
      p.pv   = ($urandom_range(0, 7) != 0);
      case (k)
        0: begin
          p.x = 0;
          p.y = 0;
        end
        1, 2, 3: begin
          p.x = ccol*8 + $urandom_range(0, 7);
          p.y = crow*16 + $urandom_range(12, 15);
        end
        4: begin
          p.x = $urandom_range(640, 2047);
          p.y = $urandom_range(0, 2047);
        end
        5: begin
          p.x = $urandom_range(0, 639);
          p.y = $urandom_range(480, 2047);
        end
        default: begin
          p.x = $urandom_range(0, 639);
          p.y = $urandom_range(0, 479);
        end
      endcase
      p.fg  = 8'($urandom);
      p.bg  = 8'($urandom);
      p.inv = 1'($urandom_range(0, 1));
      p.cen = ($urandom_range(0, 3) != 0);
      step_m(p);
    end

    for (int i = 0; i < 3; i++) begin
      p    = idle();
      p.x  = 100 + i;
      p.y  = 200;
      p.pv = 1'b1;
      p.fg = DEF_FG;
      p.bg = DEF_BG;
      step_m(p);
    end
    do_reset();

    scr[3*DEF_COLS + 5] = 8'h00;
    for (int n = 0; n < 70; n++) begin
      p    = idle();
      p.x  = 0;
      p.y  = 0;
      p.pv = 1'b1;
      p.fg = DEF_FG;
      p.bg = DEF_BG;
      step_m(p);
      p      = idle();
      p.x    = 42;
      p.y    = 63;
      p.pv   = 1'b1;
      p.cen  = 1'b1;
      p.ccol = 5;
      p.crow = 3;
      p.fg   = DEF_FG;
      p.bg   = DEF_BG;
      step(p, (((n + 1) / 32) % 2 == 1) ? DEF_FG : DEF_BG,
           1'b1, 245);
    end
    repeat (4) step_m(idle());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
